flash_reader: RTL and testbench

- Word-read controller inside `system` that drives the external 8-bit parallel flash pins: flash_address, flash_data, flash_cs_n, flash_oe_n, flash_we_n.
- Accepts 32-bit read requests from the internal fetch/data bus.
- Performs four byte reads with a programmable access wait.
- Returns one little-endian word per request. Read-only: writes and erase are out of scope.

---
 rtl/flash_pkg.sv | 8 +
 rtl/flash_reader.sv | 95 +++++++++
 tb/tb_flash_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the parallel-flash word reader.
package flash_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} flash_state_t;

   localparam int FLASH_ADDR_W   = 23;
   localparam int BYTES_PER_WORD = 4;
   localparam int FLASH_WAIT_W   = 8;
endpackage

// File: rtl/flash_reader.sv
// Reads one little-endian 32-bit word from an 8-bit parallel flash as four
// byte accesses, each held WAIT_CYCLES extra clocks before sampling.
module flash_reader
   import flash_pkg::*;
#(
   parameter int ADDR_W      = FLASH_ADDR_W,
   parameter int WAIT_CYCLES = 7
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic [ADDR_W-1:0] flash_address,
   input  logic [7:0]        flash_data,
   output logic              flash_cs_n,
   output logic              flash_oe_n,
   output logic              flash_we_n
);

   localparam logic [FLASH_WAIT_W-1:0] WAIT_INIT = FLASH_WAIT_W'(WAIT_CYCLES);
   localparam logic [1:0]              LAST_IDX  = 2'(BYTES_PER_WORD - 1);

   flash_state_t            state, state_next;
   logic [ADDR_W-3:0]       base;
   logic [1:0]              idx;
   logic [FLASH_WAIT_W-1:0] cnt;
   logic [1:0]              unused_addr_lo;

   // Word aligned: the low address bits come from the byte index.
   assign unused_addr_lo = addr[1:0];
   assign ready          = (state == IDLE);
   assign flash_we_n     = 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req) state_next = ACCESS;
         ACCESS:  if (cnt == '0 && idx == LAST_IDX) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base          <= '0;
         idx           <= '0;
         cnt           <= '0;
         rdata         <= '0;
         rvalid        <= 1'b0;
         flash_address <= '0;
         flash_cs_n    <= 1'b1;
         flash_oe_n    <= 1'b1;
      end else begin
         rvalid <= 1'b0;
         case (state)
            IDLE: if (req) begin
               base          <= addr[ADDR_W-1:2];
               flash_address <= {addr[ADDR_W-1:2], 2'b00};
               idx           <= '0;
               cnt           <= WAIT_INIT;
               flash_cs_n    <= 1'b0;
               flash_oe_n    <= 1'b0;
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rdata[8*idx +: 8] <= flash_data;
                  if (idx != LAST_IDX) begin
                     // Only the byte lane bits advance; no carry into the word address.
                     idx           <= idx + 2'd1;
                     flash_address <= {base, idx + 2'd1};
                     cnt           <= WAIT_INIT;
                  end else begin
                     flash_cs_n <= 1'b1;
                     flash_oe_n <= 1'b1;
                     rvalid     <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_reader.sv
// Randomized bench for flash_reader: two instances (WAIT_CYCLES 7 and 0)
// against a behavioural flash image and cycle-level timing model.
module tb_flash_reader;
   localparam int AW = 23;

   logic          clock, reset_n, req, sel;
   logic [AW-1:0] addr;
   logic [31:0]   seed;

   logic          req7, ready7, rvalid7, cs7, oe7, we7;
   logic [31:0]   rdata7;
   logic [AW-1:0] fa7;
   logic [7:0]    fd7;
   logic          req0, ready0, rvalid0, cs0, oe0, we0;
   logic [31:0]   rdata0;
   logic [AW-1:0] fa0;
   logic [7:0]    fd0;

   logic          rdy, rv, cs, oe, we;
   logic [31:0]   rd;
   logic [AW-1:0] fa;

   int checks = 0;
   int passed = 0;

   // Flash image: fixed test word at 0..3 when seed is 0, otherwise a hash.
   function automatic logic [7:0] byte_val(input logic [AW-1:0] a, input logic [31:0] s);
      logic [31:0] h;
      if (s == 32'd0 && a < 23'd4) begin
         case (a[1:0])
            2'd0:    return 8'h78;
            2'd1:    return 8'h56;
            2'd2:    return 8'h34;
            default: return 8'h12;
         endcase
      end
      h = ({9'd0, a} ^ s) * 32'h9E3779B1;
      return h[31:24] ^ h[15:8];
   endfunction

   function automatic logic [31:0] model_word(input logic [AW-1:0] a, input logic [31:0] s);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = byte_val({a[AW-1:2], 2'(k)}, s);
      return w;
   endfunction

   assign req7 = req & ~sel;
   assign req0 = req & sel;
   assign fd7  = byte_val(fa7, seed);
   assign fd0  = byte_val(fa0, seed);

   assign rdy = sel ? ready0  : ready7;
   assign rv  = sel ? rvalid0 : rvalid7;
   assign cs  = sel ? cs0     : cs7;
   assign oe  = sel ? oe0     : oe7;
   assign we  = sel ? we0     : we7;
   assign rd  = sel ? rdata0  : rdata7;
   assign fa  = sel ? fa0     : fa7;

   flash_reader #(.ADDR_W(AW), .WAIT_CYCLES(7)) dut7 (
      .clock(clock), .reset_n(reset_n), .req(req7), .addr(addr),
      .ready(ready7), .rdata(rdata7), .rvalid(rvalid7),
      .flash_address(fa7), .flash_data(fd7),
      .flash_cs_n(cs7), .flash_oe_n(oe7), .flash_we_n(we7));

   flash_reader #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .req(req0), .addr(addr),
      .ready(ready0), .rdata(rdata0), .rvalid(rvalid0),
      .flash_address(fa0), .flash_data(fd0),
      .flash_cs_n(cs0), .flash_oe_n(oe0), .flash_we_n(we0));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One word read on the selected instance, checked every cycle from acceptance
   // until ready returns. chain_in: req already held; chain_next: keep req high
   // with next_a during the busy period.
   task automatic run_read(input logic [AW-1:0] a, input bit chain_in,
                           input bit chain_next, input logic [AW-1:0] next_a,
                           input string tag);
      int per, last;
      bit ok;
      logic [AW-1:0] base;
      logic [31:0]   exp;
      logic [27:0]   obs, want;
      per  = sel ? 1 : 8;
      last = 4 * per;
      base = {a[AW-1:2], 2'b00};
      exp  = model_word(a, seed);
      if (!chain_in) begin
         ok = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (rdy === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
         end
         checks++;
         if (!ok) begin
            $display("FAIL %s ready_wait: ready=%b required 1 within 200 cycles", tag, rdy);
            return;
         end
         passed++;
         req  = 1'b1;
         addr = a;
      end
      @(posedge clock);
      @(negedge clock);
      if (chain_next) addr = next_a;
      else            req  = 1'b0;
      for (int n = 0; n <= last + 1; n++) begin
         obs = {fa, cs, oe, we, rv, rdy};
         if (n < last)       want = {base | 23'(n / per), 5'b00100};
         else if (n == last) want = {base | 23'd3,       5'b11110};
         else                want = {base | 23'd3,       5'b11101};
         checks++;
         if (obs !== want)
            $display("FAIL %s cycle%0d {addr,cs,oe,we,rvalid,ready}: got %h required %h",
                     tag, n, obs, want);
         else passed++;
         if (n == last) begin
            checks++;
            if (rd !== exp) $display("FAIL %s rdata: got %h required %h", tag, rd, exp);
            else passed++;
         end
         if (n <= last) @(negedge clock);
      end
   endtask

   task automatic test_reset();
      logic [59:0] obs;
      logic [9:0]  strobes;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         obs = {fa, rd, cs, oe, we, rv, rdy};
         checks++;
         if (obs !== {23'd0, 32'd0, 5'b11101})
            $display("FAIL reset_values dut%0d: got %h required %h", s, obs, {23'd0, 32'd0, 5'b11101});
         else passed++;
      end
      sel = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         strobes = {cs7, oe7, we7, rvalid7, ready7, cs0, oe0, we0, rvalid0, ready0};
         checks++;
         if (strobes !== 10'b11101_11101)
            $display("FAIL idle_strobes cycle%0d: got %b required 1110111101", i, strobes);
         else passed++;
      end
   endtask

   task automatic test_fixed_word();
      sel  = 1'b0;
      seed = 32'd0;
      run_read(23'h000000, 1'b0, 1'b0, '0, "fixed_word");
      checks++;
      if (rd !== 32'h12345678) $display("FAIL fixed_word_hold: got %h required 12345678", rd);
      else passed++;
   endtask

   task automatic test_unaligned();
      sel  = 1'b0;
      seed = $urandom | 32'd1;
      run_read(23'h000106, 1'b0, 1'b0, '0, "unaligned_106");
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int i = 0; i < 10; i++) begin
         sel  = (i >= 4);
         seed = $urandom | 32'd1;
         a    = AW'($urandom);
         run_read(a, 1'b0, 1'b0, '0, sel ? "random_w0" : "random_w7");
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a1, a2, a3;
      sel  = 1'b1;
      seed = $urandom | 32'd1;
      a1 = AW'($urandom); a2 = AW'($urandom); a3 = AW'($urandom);
      run_read(a1, 1'b0, 1'b1, a2, "b2b_first");
      run_read(a2, 1'b1, 1'b1, a3, "b2b_second");
      run_read(a3, 1'b1, 1'b0, '0, "b2b_third");
   endtask

   task automatic test_top_addr();
      sel  = 1'b0;
      seed = $urandom | 32'd1;
      run_read(23'h7FFFFC, 1'b0, 1'b0, '0, "top_addr");
      sel = 1'b1;
      run_read(23'h7FFFFF, 1'b0, 1'b0, '0, "top_addr_unaligned");
   endtask

   task automatic test_reset_mid();
      logic [59:0] obs;
      sel  = 1'b0;
      seed = $urandom | 32'd1;
      run_read(AW'($urandom), 1'b0, 1'b0, '0, "pre_abort");
      req  = 1'b1;
      addr = AW'($urandom);
      @(posedge clock);
      @(negedge clock);
      req = 1'b0;
      repeat (12) @(negedge clock);
      checks++;
      if (cs !== 1'b0) $display("FAIL abort_busy cs_n: got %b required 0", cs);
      else passed++;
      reset_n = 1'b0;
      #1;
      obs = {fa, rd, cs, oe, we, rv, rdy};
      checks++;
      if (obs !== {23'd0, 32'd0, 5'b11101})
         $display("FAIL abort_async_reset: got %h required %h", obs, {23'd0, 32'd0, 5'b11101});
      else passed++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (i == 2) reset_n = 1'b1;
         checks++;
         if ({cs, oe, rv} !== 3'b110)
            $display("FAIL abort_quiet cycle%0d {cs,oe,rvalid}: got %b required 110", i, {cs, oe, rv});
         else passed++;
      end
      run_read(AW'($urandom), 1'b0, 1'b0, '0, "post_abort");
   endtask

   initial begin
      sel     = 1'b0;
      req     = 1'b0;
      addr    = '0;
      seed    = 32'd1;
      reset_n = 1'b0;
      test_reset();
      test_fixed_word();
      test_unaligned();
      test_random();
      test_back_to_back();
      test_top_addr();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
